// File: rtl/ysyx_24110006_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_24110006_ifu -- instruction fetch unit for the multi-cycle core.
//
// Fetches one 32-bit instruction per PC over an AXI4-Lite read channel and
// hands it to the decoder as a single-cycle valid pulse, then waits for
// writeback to supply the next PC. Misaligned PCs are reported without
// touching the bus; non-OKAY read responses are reported as access faults.
//
// Ports:
//   i_clock, i_reset         core clock, asynchronous active-high reset
//   i_pc_valid, i_next_pc    next-PC strobe and value from writeback
//   o_araddr, o_arvalid,
//   i_arready                AXI read-address channel
//   i_rdata, i_rresp,
//   i_rvalid, o_rready       AXI read-data channel
//   o_pc, o_inst, o_valid    instruction presented to the decoder
//   o_fault                  0 none, 1 misaligned PC, 2 bus fault (with o_valid)
//   o_fetch_cnt              o_valid pulses since reset (wraps)
// ---------------------------------------------------------------------------
module ysyx_24110006_ifu #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_pc_valid,
  input  logic [31:0] i_next_pc,
  output logic [31:0] o_araddr,
  output logic        o_arvalid,
  input  logic        i_arready,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  input  logic        i_rvalid,
  output logic        o_rready,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic        o_valid,
  output logic [1:0]  o_fault,
  output logic [31:0] o_fetch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_OUT  = 3'd3,
    S_WAIT = 3'd4
  } state_t;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] FAULT_BUS      = 2'd2;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] inst_r;
  logic [1:0]  fault_r;
  logic [31:0] fetch_cnt_r;

  // Fetch FSM together with the PC, instruction, fault and counter registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_r     <= S_IDLE;
      pc_r        <= RESET_PC;
      inst_r      <= 32'd0;
      fault_r     <= FAULT_NONE;
      fetch_cnt_r <= 32'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          state_r <= S_AR;
        end
        S_AR: begin
          // Address and valid are decoded from state/pc_r, so they cannot
          // change while the slave stalls.
          if (i_arready) begin
            state_r <= S_R;
          end
        end
        S_R: begin
          if (i_rvalid) begin
            if (i_rresp == 2'b00) begin
              inst_r  <= i_rdata;
              fault_r <= FAULT_NONE;
            end else begin
              inst_r  <= 32'd0;
              fault_r <= FAULT_BUS;
            end
            state_r <= S_OUT;
          end
        end
        S_OUT: begin
          fetch_cnt_r <= fetch_cnt_r + 32'd1;
          state_r     <= S_WAIT;
        end
        S_WAIT: begin
          if (i_pc_valid) begin
            pc_r <= i_next_pc;
            if (i_next_pc[1:0] == 2'b00) begin
              state_r <= S_AR;
            end else begin
              // Misaligned target: report immediately, never reach the bus.
              inst_r  <= 32'd0;
              fault_r <= FAULT_MISALIGN;
              state_r <= S_OUT;
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign o_arvalid   = (state_r == S_AR);
  assign o_rready    = (state_r == S_R);
  assign o_valid     = (state_r == S_OUT);
  assign o_araddr    = pc_r;
  assign o_pc        = pc_r;
  assign o_inst      = inst_r;
  assign o_fault     = fault_r;
  assign o_fetch_cnt = fetch_cnt_r;

endmodule
